// File: rtl/pitch_cv_glide.sv
// Pitch CV conditioner: captures the CV on each sample strobe and slews the output toward it.
// The slew rate comes from a rate CV. A deadband ignores small jitter, and hold freezes the output.
module pitch_cv_glide #(
   parameter int W          = 16,
   parameter int DEADBAND   = 16,
   parameter int STEP_SHIFT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_clk,
   input  logic signed [W-1:0] cv_in,
   input  logic signed [W-1:0] rate_in,
   input  logic                hold,
   output logic signed [W-1:0] cv_out,
   output logic                slewing
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SLEW = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [W:0] DB = (W+1)'(DEADBAND);

   state_t              r_state;
   logic                r_sclk_q;
   logic                r_v1;
   logic                r_v2;
   logic signed [W-1:0] r_cv_cap;
   logic [7:0]          r_code;
   logic signed [W-1:0] r_tgt2;
   logic                r_neg;
   logic [W:0]          r_abs;
   logic [W-1:0]        r_step;
   logic                r_bypass;
   logic                r_exceed;
   logic signed [W-1:0] r_target;
   logic signed [W-1:0] r_cv_out;
   logic                r_slewing;

   logic                w_tick;
   logic                w_accept;
   logic [7:0]          w_code;
   logic signed [W:0]   w_diff;
   logic [W:0]          w_abs;
   logic [W-1:0]        w_step;
   logic                w_move;
   logic                w_snap;
   logic signed [W-1:0] w_tgt_next;
   logic signed [W-1:0] w_stepped;
   logic signed [W-1:0] w_out_next;
   logic                w_settled;

   // A tick is only taken when the two-stage pipeline is empty and hold is low.
   assign w_tick   = sample_clk & ~r_sclk_q;
   assign w_accept = w_tick & ~r_v1 & ~r_v2 & ~hold;
   assign w_code   = rate_in[W-1] ? 8'd0 : rate_in[W-2:W-9];

   // Stage 2: distance to the captured CV and the step size.
   // The W+1 width keeps a full-scale swing from overflowing.
   assign w_diff = {r_cv_cap[W-1], r_cv_cap} - {r_cv_out[W-1], r_cv_out};
   assign w_abs  = w_diff[W] ? (~w_diff + (W+1)'(1)) : w_diff;
   assign w_step = ({{(W-8){1'b0}}, r_code} + W'(1)) << STEP_SHIFT;

   // Stage 3: IDLE only moves when the deadband was exceeded; SLEW always chases the new CV.
   assign w_move     = (r_state == S_SLEW) | r_exceed;
   assign w_snap     = r_bypass | (r_abs <= {1'b0, r_step});
   assign w_tgt_next = w_move ? r_tgt2 : r_target;
   assign w_stepped  = r_neg ? (r_cv_out - r_step) : (r_cv_out + r_step);
   assign w_out_next = !w_move ? r_cv_out : (w_snap ? r_tgt2 : w_stepped);
   assign w_settled  = (w_out_next == w_tgt_next);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_sclk_q  <= 1'b0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_cv_cap  <= '0;
         r_code    <= '0;
         r_tgt2    <= '0;
         r_neg     <= 1'b0;
         r_abs     <= '0;
         r_step    <= '0;
         r_bypass  <= 1'b0;
         r_exceed  <= 1'b0;
         r_target  <= '0;
         r_cv_out  <= '0;
         r_slewing <= 1'b0;
      end else begin
         r_sclk_q <= sample_clk;
         if (hold) begin
            r_state   <= S_HOLD;
            r_slewing <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
         end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            if (r_state == S_HOLD)
               r_state <= S_IDLE;
            if (r_v2 && w_move) begin
               r_target  <= w_tgt_next;
               r_cv_out  <= w_out_next;
               r_state   <= w_settled ? S_IDLE : S_SLEW;
               r_slewing <= ~w_settled;
            end
         end
         if (w_accept) begin
            r_cv_cap <= cv_in;
            r_code   <= w_code;
         end
         if (r_v1) begin
            r_tgt2   <= r_cv_cap;
            r_neg    <= w_diff[W];
            r_abs    <= w_abs;
            r_step   <= w_step;
            r_bypass <= (r_code == 8'hFF);
            r_exceed <= (w_abs > DB);
         end
      end
   end

   assign cv_out  = r_cv_out;
   assign slewing = r_slewing;

endmodule

// File: tb/tb_pitch_cv_glide.sv
// Bench for pitch_cv_glide: an arithmetic reference model is compared every cycle.
// Directed scenarios also check hand-computed values.
module tb_pitch_cv_glide;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               sample_clk = 1'b0;
   logic               hold = 1'b0;
   logic signed [15:0] cv_in = '0;
   logic signed [15:0] rate_in = '0;
   logic signed [15:0] cv_out;
   logic               slewing;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pitch_cv_glide #(.W(16), .DEADBAND(16), .STEP_SHIFT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_clk (sample_clk),
      .cv_in      (cv_in),
      .rate_in    (rate_in),
      .hold       (hold),
      .cv_out     (cv_out),
      .slewing    (slewing)
   );

   // Reference model: plain integer arithmetic from the behavioural rules.
   int m_out = 0;
   int m_tgt = 0;
   int m_state = 0;   // 0 idle, 1 slew, 2 hold
   bit m_sq = 0;
   bit p_valid = 0;
   int p_cnt = 0;
   int p_cv = 0;
   int p_rate = 0;

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic void model_update(int cv, int rate);
      int code;
      int step;
      int d;
      code = (rate < 0) ? 0 : (rate / 128);
      step = (code + 1) * 16;
      if (m_state == 0 && iabs(cv - m_out) <= 16)
         return;
      m_tgt = cv;
      d = m_tgt - m_out;
      if (code == 255 || iabs(d) <= step)
         m_out = m_tgt;
      else
         m_out = m_out + ((d > 0) ? step : -step);
      m_state = (m_out == m_tgt) ? 0 : 1;
   endfunction

   always @(posedge clk) begin
      bit tk;
      bit busy;
      if (!rst) begin
         m_out = 0; m_tgt = 0; m_state = 0; m_sq = 0; p_valid = 0; p_cnt = 0;
      end else begin
         tk = sample_clk && !m_sq;
         busy = p_valid;
         if (hold) begin
            m_state = 2;
            p_valid = 0;
         end else begin
            if (m_state == 2)
               m_state = 0;
            if (p_valid) begin
               p_cnt = p_cnt - 1;
               if (p_cnt == 0) begin
                  model_update(p_cv, p_rate);
                  p_valid = 0;
               end
            end
            if (tk && !busy) begin
               p_valid = 1;
               p_cnt = 2;
               p_cv = int'(cv_in);
               p_rate = int'(rate_in);
            end
         end
         m_sq = sample_clk;
      end
   end

   always @(negedge clk) begin
      n_checks++;
      if (int'(cv_out) != m_out || slewing !== (m_state == 1)) begin
         n_errors++;
         if (n_errors < 30)
            $display("FAIL model t=%0t cv_out=%0d slewing=%0b expected cv_out=%0d slewing=%0b",
                     $time, cv_out, slewing, m_out, (m_state == 1));
      end
   end

   task automatic chk(string name, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // One strobe, cv/rate held from the tick cycle onward; returns just after the update edge.
   task automatic do_tick(int cv, int rate);
      @(posedge clk); #1;
      cv_in = 16'(cv);
      rate_in = 16'(rate);
      sample_clk = 1'b1;
      @(posedge clk); #1;
      sample_clk = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
   endtask

   initial begin
      // Reset with ticks running
      repeat (3) do_tick(1234, 0);
      chk("rst_cv_out", int'(cv_out), 0);
      chk("rst_slewing", int'(slewing), 0);
      @(posedge clk); #1 rst = 1'b1;
      do_tick(0, 0);
      chk("post_rst_cv_out", int'(cv_out), 0);

      // A second strobe only 2 cycles later is dropped; a held-high strobe ticks once
      @(posedge clk); #1 cv_in = 16'sd100; rate_in = '0; sample_clk = 1'b1;
      @(posedge clk); #1 sample_clk = 1'b0;
      @(posedge clk); #1 sample_clk = 1'b1;
      @(posedge clk); #1 sample_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("drop_close_tick", int'(cv_out), 16);
      @(posedge clk); #1 sample_clk = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("held_strobe", int'(cv_out), 32);
      sample_clk = 1'b0;
      pulse_reset();

      // Slew 0 -> 8000 at step 16, with hold episodes mid-slew
      for (int k = 1; k <= 500; k++) begin
         if (k == 100) begin
            @(posedge clk); #1 cv_in = 16'sd8000; sample_clk = 1'b1;
            @(posedge clk); #1 sample_clk = 1'b0; hold = 1'b1;
            @(posedge clk); #1 hold = 1'b0;
            @(posedge clk);
            @(posedge clk); #1;
            chk("hold_discards_tick", int'(cv_out), 1584);
            chk("hold_discard_slewing", int'(slewing), 0);
         end
         if (k == 251) begin
            @(posedge clk); #1 hold = 1'b1;
            for (int j = 0; j < 10; j++) begin
               @(posedge clk); #1 cv_in = 16'sd8000; sample_clk = 1'b1;
               @(posedge clk); #1 sample_clk = 1'b0;
               @(posedge clk);
            end
            #1 chk("hold_frozen", int'(cv_out), 4000);
            chk("hold_slewing", int'(slewing), 0);
            @(posedge clk); #1 hold = 1'b0;
         end
         do_tick(8000, 0);
         chk("slew_step", int'(cv_out), 16 * k);
         if (k == 1) chk("slew_start", int'(slewing), 1);
      end
      chk("slew_done", int'(slewing), 0);

      // Deadband around 1000
      do_tick(1000, 'h7FFF);
      chk("bypass_1000", int'(cv_out), 1000);
      do_tick(1010, 0);
      chk("db_1010", int'(cv_out), 1000);
      do_tick(1016, 0);
      chk("db_1016", int'(cv_out), 1000);
      do_tick(1017, 0);
      chk("db_1017", int'(cv_out), 1016);
      chk("db_1017_slewing", int'(slewing), 1);
      do_tick(1017, 0);
      chk("db_settle", int'(cv_out), 1017);

      // Bypass latency: unchanged 2 edges after the strobe edge, new value after the 3rd
      @(posedge clk); #1 cv_in = -16'sd20000; rate_in = 16'h7FFF; sample_clk = 1'b1;
      @(posedge clk); #1 sample_clk = 1'b0;
      @(posedge clk); #1 chk("bypass_early", int'(cv_out), 1017);
      @(posedge clk); #1 chk("bypass_value", int'(cv_out), -20000);
      chk("bypass_slewing", int'(slewing), 0);

      // Full-scale swing at step 4080
      do_tick(-32768, 'h7FFF);
      chk("fs_start", int'(cv_out), -32768);
      for (int k = 1; k <= 17; k++) begin
         do_tick(32767, 'h7F00);
         chk("fs_step", int'(cv_out), (k < 17) ? (-32768 + 4080 * k) : 32767);
         chk("fs_slewing", int'(slewing), (k < 17) ? 1 : 0);
      end

      // Reset mid-slew
      repeat (3) do_tick(0, 0);
      chk("pre_rst_cv_out", int'(cv_out), 32767 - 48);
      pulse_reset();
      chk("mid_rst_cv_out", int'(cv_out), 0);
      chk("mid_rst_slewing", int'(slewing), 0);
      do_tick(5, 0);
      chk("after_rst_idle", int'(cv_out), 0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
